mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_mac_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Dot-product command sequencer: accepts a length, streams operand pairs one at a
// time into an external MAC unit and returns the accumulated fp16 result.
module mac_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_len,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        pu_start,
    output logic        pu_clear,
    output logic [15:0] pu_a,
    output logic [15:0] pu_b,
    input  logic        pu_ready,
    input  logic [15:0] pu_p,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_OP, WAIT_PU, RESULT, ERROR} state_t;

    state_t          state, state_nxt;
    logic [4:0]      len_q, cnt_q;
    logic [WD_W-1:0] wdog_q;
    logic            first_q;
    logic            len_zero, len_bad, last_elem, wd_expire;

    assign len_zero  = (cmd_len == 5'd0);
    assign len_bad   = ({27'd0, cmd_len} > MAX_LEN);
    assign last_elem = ((cnt_q + 5'd1) == len_q);
    // Expiry is flagged on the last allowed cycle so err lands TIMEOUT cycles after pu_start.
    assign wd_expire = (wdog_q == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        pu_clear  = 1'b0;
        pu_start  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (len_zero)     state_nxt = RESULT;
                    else if (len_bad) state_nxt = ERROR;
                    else              state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                pu_clear  = 1'b1;
                state_nxt = WAIT_OP;
            end
            WAIT_OP: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = WAIT_PU;
            end
            WAIT_PU: begin
                pu_start = first_q;
                // A completion in the expiry cycle still wins over the watchdog.
                if (pu_ready)       state_nxt = last_elem ? RESULT : WAIT_OP;
                else if (wd_expire) state_nxt = ERROR;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            ERROR: begin
                busy = 1'b0;
                if (err_clr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            cnt_q    <= '0;
            wdog_q   <= '0;
            first_q  <= 1'b0;
            pu_a     <= '0;
            pu_b     <= '0;
            res_data <= '0;
            err      <= 1'b0;
        end else begin
            first_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q <= cmd_len;
                        cnt_q <= '0;
                        if (len_zero)     res_data <= '0;
                        else if (len_bad) err      <= 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (op_valid) begin
                        pu_a    <= op_a;
                        pu_b    <= op_b;
                        wdog_q  <= '0;
                        first_q <= 1'b1;
                    end
                end
                WAIT_PU: begin
                    if (pu_ready) begin
                        cnt_q <= cnt_q + 5'd1;
                        if (last_elem) res_data <= pu_p;
                    end else if (wd_expire) begin
                        err <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WD_ONE;
                    end
                end
                ERROR: begin
                    if (err_clr) err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: vector table of commands, behavioural fp16 MAC unit,
// result scoreboard plus hand-written timeout and mid-command reset sequences.
module tb_mac_sequencer;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_len = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        pu_start, pu_clear;
    logic [15:0] pu_a, pu_b;
    logic        pu_ready = 1'b0;
    logic [15:0] pu_p = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy, err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .pu_start(pu_start), .pu_clear(pu_clear), .pu_a(pu_a), .pu_b(pu_b),
        .pu_ready(pu_ready), .pu_p(pu_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    typedef struct packed { logic [15:0] a; logic [15:0] b; } op_t;
    typedef struct {
        logic [4:0]  len;
        logic [15:0] a;
        logic [15:0] b;
        bit          gap;
        int          hold;
        bit          exp_err;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vt [8];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, n_start = 0, n_clr = 0, n_res = 0, n_hs = 0;
    int   acc_cyc = 0, start_cyc = 0, err_cyc = 0, res_first_cyc = 0;
    bit   acc_seen = 0, in_pu = 0, prev_rv = 0, prev_rr = 0, prev_err = 0;
    logic [15:0] prev_rd = '0;
    op_t  cur;
    logic [15:0] sb_q [$];
    op_t  hs_q [$];

    // fp16 helpers for the MAC model (normal numbers only)
    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = real'(h[9:0]) / 1024.0;
        if (e == 0) e = 1;
        else        m = m + 1.0;
        e = e - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        int   e, mi;
        real  m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        mi = $rtoi((m - 1.0) * 1024.0 + 0.5);
        return {s, 5'(e), 10'(mi)};
    endfunction

    // Behavioural MAC unit: pu_ready arrives mac_lat cycles after pu_start.
    int          mac_lat = 13;
    bit          mac_hang = 0;
    real         acc = 0.0;
    logic [15:0] m_a = '0, m_b = '0;
    int          m_cnt = 0;
    bit          m_busy = 0;

    always @(negedge clk) begin
        pu_ready = 1'b0;
        if (pu_clear) acc = 0.0;
        if (pu_start) begin
            m_a = pu_a; m_b = pu_b; m_cnt = mac_lat; m_busy = !mac_hang;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                acc      = acc + h2r(m_a) * h2r(m_b);
                pu_p     = r2h(acc);
                pu_ready = 1'b1;
                m_busy   = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        cyc++;
        if (cmd_valid && cmd_ready) begin acc_seen = 1; acc_cyc = cyc; end
        if (op_valid && op_ready) begin hs_q.push_back({op_a, op_b}); n_hs++; end
        if (pu_clear) n_clr++;
        if (pu_start) begin
            n_start++;
            start_cyc = cyc;
            if (hs_q.size() == 0) check("pu_start_without_op", hs_q.size(), 1);
            else begin
                cur = hs_q.pop_front();
                check("pu_operands", {pu_a, pu_b}, cur);
                in_pu = 1;
            end
        end else if (in_pu) begin
            if (op_ready || res_valid || !busy) in_pu = 0;
            else check("pu_hold", {pu_a, pu_b}, cur);
        end
        if (prev_rv && !prev_rr) begin
            check("res_valid_hold", 32'(res_valid), 1);
            check("res_data_hold", 32'(res_data), 32'(prev_rd));
        end
        if (res_valid && !prev_rv) res_first_cyc = cyc;
        if (res_valid && res_ready) begin
            n_res++;
            if (sb_q.size() == 0) check("res_unexpected", sb_q.size(), 1);
            else check("res_data", 32'(res_data), 32'(sb_q.pop_front()));
        end
        if (err && !prev_err) err_cyc = cyc;
        prev_rv = res_valid; prev_rr = res_ready; prev_rd = res_data; prev_err = err;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, 32'({cmd_ready, op_ready, pu_start, pu_clear, res_valid, busy, err}),
              32'b1000000);
        check({name, "_pu_ab"}, {pu_a, pu_b}, 0);
        check({name, "_res"}, 32'(res_data), 0);
    endtask

    task automatic wait_op_hs(input logic [15:0] a, input logic [15:0] b);
        int h0, guard;
        op_valid = 1; op_a = a; op_b = b;
        h0 = n_hs; guard = 0;
        while (n_hs == h0 && guard < 200) begin tick(); guard++; end
        op_valid = 0;
        check("op_wait", 32'(guard < 200), 1);
    endtask

    task automatic run_cmd(input vec_t v);
        int s0, c0, r0, guard;
        s0 = n_start; c0 = n_clr; r0 = n_res;
        acc_seen = 0;
        cmd_valid = 1; cmd_len = v.len;
        if (!v.exp_err) sb_q.push_back(v.exp_res);
        tick();
        cmd_valid = 0;
        check("cmd_accept", 32'(acc_seen), 1);
        if (v.exp_err) begin
            check("err_set", 32'(err), 1);
            check("err_handshakes", {29'd0, busy, cmd_ready, op_ready}, 0);
            err_clr = 1; cmd_valid = 1; cmd_len = 5'd1; acc_seen = 0;
            tick();
            err_clr = 0; cmd_valid = 0;
            check("err_clr", 32'(err), 0);
            check("err_clr_no_accept", 32'(acc_seen), 0);
            check("err_clr_cmd_ready", 32'(cmd_ready), 1);
            check("err_no_pu", n_start - s0 + n_clr - c0, 0);
            return;
        end
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.gap) repeat ($urandom_range(0, 3)) tick();
            wait_op_hs(v.a, v.b);
        end
        guard = 0;
        while (!res_valid && guard < 500) begin tick(); guard++; end
        check("res_wait", 32'(guard < 500), 1);
        repeat (v.hold) tick();
        res_ready = 1; guard = 0;
        while (n_res == r0 && guard < 50) begin tick(); guard++; end
        res_ready = 0;
        check("res_pop", n_res - r0, 1);
        check("cmd_ready_b2b", 32'(cmd_ready), 1);
        check("start_count", n_start - s0, int'(v.len));
        check("clear_count", n_clr - c0, (v.len != 0) ? 1 : 0);
        if (v.len == 0) check("len0_latency", res_first_cyc - acc_cyc, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   guard, s0, s1, c0, r0, h0;
        vec_t v;
        vt[0] = '{len: 5'd3,  a: 16'h3C00, b: 16'h4000, gap: 0, hold: 0, exp_err: 0, exp_res: 16'h4600};
        vt[1] = '{len: 5'd0,  a: 16'h0000, b: 16'h0000, gap: 0, hold: 0, exp_err: 0, exp_res: 16'h0000};
        vt[2] = '{len: 5'd1,  a: 16'h4000, b: 16'h4000, gap: 0, hold: 1, exp_err: 0, exp_res: 16'h4400};
        vt[3] = '{len: 5'd2,  a: 16'h4200, b: 16'h4000, gap: 1, hold: 0, exp_err: 0, exp_res: 16'h4A00};
        vt[4] = '{len: 5'd20, a: 16'h3C00, b: 16'h3C00, gap: 0, hold: 0, exp_err: 1, exp_res: 16'h0000};
        vt[5] = '{len: 5'd16, a: 16'h3C00, b: 16'h3C00, gap: 0, hold: 0, exp_err: 0, exp_res: 16'h4C00};
        vt[6] = '{len: 5'd17, a: 16'h3C00, b: 16'h3C00, gap: 0, hold: 0, exp_err: 1, exp_res: 16'h0000};
        vt[7] = '{len: 5'd4,  a: 16'h3800, b: 16'h4000, gap: 1, hold: 5, exp_err: 0, exp_res: 16'h4400};

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        foreach (vt[i]) run_cmd(vt[i]);

        // Watchdog: MAC never answers.
        mac_hang = 1;
        cmd_valid = 1; cmd_len = 5'd1;
        tick();
        cmd_valid = 0;
        wait_op_hs(16'h3C00, 16'h3C00);
        guard = 0;
        while (!err && guard < 100) begin tick(); guard++; end
        tick();
        check("timeout_wait", 32'(guard < 100), 1);
        check("timeout_cycles", err_cyc - start_cyc, TIMEOUT);
        check("timeout_state", {29'd0, busy, res_valid, op_ready}, 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("timeout_err_clr", 32'(err), 0);

        // Completion on the last watchdog cycle beats the timeout.
        mac_hang = 0; mac_lat = TIMEOUT - 1;
        v = '{len: 5'd1, a: 16'h3C00, b: 16'h3C00, gap: 0, hold: 0, exp_err: 0, exp_res: 16'h3C00};
        run_cmd(v);
        check("late_ready_no_err", 32'(err), 0);
        mac_lat = 13;

        // Reset during the second element of a 4-element command.
        cmd_valid = 1; cmd_len = 5'd4;
        tick();
        cmd_valid = 0;
        s0 = n_start;
        wait_op_hs(16'h3C00, 16'h4000);
        wait_op_hs(16'h3C00, 16'h4000);
        guard = 0;
        while (n_start < s0 + 2 && guard < 50) begin tick(); guard++; end
        tick();
        check("mid_reset_in_pu", {30'd0, busy, op_ready}, 32'b10);
        reset = 1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        check_reset_outputs("held_reset");
        reset = 0;
        hs_q.delete();
        in_pu = 0;
        s1 = n_start; c0 = n_clr; r0 = n_res; h0 = n_hs;
        op_valid = 1; op_a = 16'h1234; op_b = 16'h5678;
        repeat (20) tick();
        op_valid = 0;
        check("post_reset_no_start", n_start - s1, 0);
        check("post_reset_no_clear", n_clr - c0, 0);
        check("post_reset_no_res", n_res - r0, 0);
        check("idle_op_not_consumed", n_hs - h0, 0);
        check("post_reset_idle", {30'd0, cmd_ready, busy}, 32'b10);
        v = '{len: 5'd1, a: 16'h4000, b: 16'h4000, gap: 0, hold: 0, exp_err: 0, exp_res: 16'h4400};
        run_cmd(v);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
